// File: rtl/gelato_warpskd_collector_buf.sv
// Warp-scheduler to operand-collector buffer: DEPTH-entry FIFO with round-robin dispatch
// to free collectors. Define GELATO_WARPSKD_COLLECTOR_BUF_STATS_EN to enable the stat counters.
module gelato_warpskd_collector_buf #(
  parameter int INST_WIDTH     = 64,
  parameter int DEPTH          = 4,
  parameter int NUM_COLLECTORS = 2,
  parameter int CNT_W          = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [INST_WIDTH-1:0]     in_inst,
  output logic                      in_ready,
  input  logic [NUM_COLLECTORS-1:0] coll_free,
  output logic [NUM_COLLECTORS-1:0] issue_valid,
  output logic [INST_WIDTH-1:0]     issue_inst,
  output logic [$clog2(DEPTH):0]    count,
  output logic [CNT_W-1:0]          stat_issued,
  output logic [CNT_W-1:0]          stat_stall
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int RR_W  = (NUM_COLLECTORS > 1) ? $clog2(NUM_COLLECTORS) : 1;

  logic [INST_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [RR_W-1:0]       rr_ptr;

  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  dispatch;
  logic                  hi_found;
  logic                  lo_found;
  logic [RR_W-1:0]       hi_idx;
  logic [RR_W-1:0]       lo_idx;
  logic [RR_W-1:0]       sel_idx;
  logic [RR_W-1:0]       rr_next;

  assign empty    = (count == '0);
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign in_ready = ~full;
  assign push     = in_valid & in_ready & ~flush;

  // Round-robin pick: lowest free unit at or above rr_ptr, else lowest free unit overall.
  // NOTE: every variable gets a default before the loop so always_comb never infers a latch.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_COLLECTORS - 1; i >= 0; i--) begin
      if (coll_free[i]) begin
        lo_found = 1'b1;
        lo_idx   = RR_W'(i);
        if (RR_W'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_idx   = RR_W'(i);
        end
      end
    end
  end

  assign sel_idx  = hi_found ? hi_idx : lo_idx;
  assign rr_next  = (sel_idx == RR_W'(NUM_COLLECTORS - 1)) ? '0 : sel_idx + 1'b1;
  assign dispatch = rst_n & ~flush & ~empty & lo_found;

  assign issue_valid = dispatch ? (NUM_COLLECTORS'(1) << sel_idx) : '0;
  assign issue_inst  = empty ? '0 : mem[head];

  // NOTE: storage carries no reset; empty masking keeps stale contents off issue_inst.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= in_inst;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      rr_ptr <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (dispatch) begin
        head   <= head + 1'b1;
        rr_ptr <= rr_next;
      end
      case ({push, dispatch})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef GELATO_WARPSKD_COLLECTOR_BUF_STATS_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (dispatch) begin
        stat_issued <= stat_issued + 1'b1;
      end
      if (~empty && (coll_free == '0) && ~flush) begin
        stat_stall <= stat_stall + 1'b1;
      end
    end
  end
`else
  assign stat_issued = '0;
  assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_gelato_warpskd_collector_buf.sv
// Scoreboard bench for gelato_warpskd_collector_buf: queue-based reference model predicts
// dispatches (instruction + collector); a negedge monitor consumes them.
module tb_gelato_warpskd_collector_buf;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int NC    = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_inst = '0;
  logic          in_ready;
  logic [NC-1:0] coll_free = '0;
  logic [NC-1:0] issue_valid;
  logic [W-1:0]  issue_inst;
  logic [$clog2(DEPTH):0] count;
  logic [CW-1:0] stat_issued;
  logic [CW-1:0] stat_stall;

  gelato_warpskd_collector_buf #(
    .INST_WIDTH(W), .DEPTH(DEPTH), .NUM_COLLECTORS(NC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_inst(in_inst),
    .in_ready(in_ready), .coll_free(coll_free), .issue_valid(issue_valid),
    .issue_inst(issue_inst), .count(count), .stat_issued(stat_issued), .stat_stall(stat_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] inst;
    int           coll;
  } exp_t;

  exp_t          exp_q[$];
  logic [W-1:0]  q[$];
  int            m_rr = 0;
  logic [CW-1:0] m_issued = '0;
  logic [CW-1:0] m_stall = '0;
  int            n_cmp = 0;
  int            n_fail = 0;
  int            seq = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One cycle: drive inputs after the edge, compare registered outputs with the model,
  // queue the predicted dispatch, then advance the model to the next edge.
  task automatic cycle(input logic rv, input logic v, input logic [W-1:0] d,
                       input logic [NC-1:0] f, input logic fl);
    logic disp;
    logic pu;
    int   sel;
    @(posedge clk);
    #1;
    rst_n = rv; in_valid = v; in_inst = d; coll_free = f; flush = fl;
    check("count", 64'(count), 64'(q.size()));
    check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    if (q.size() == 0) check("inst_idle", 64'(issue_inst), 64'd0);
`ifdef GELATO_WARPSKD_COLLECTOR_BUF_STATS_EN
    check("stat_issued", 64'(stat_issued), 64'(m_issued));
    check("stat_stall", 64'(stat_stall), 64'(m_stall));
`else
    check("stat_issued", 64'(stat_issued), 64'd0);
    check("stat_stall", 64'(stat_stall), 64'd0);
`endif
    sel = -1;
    for (int k = 0; k < NC; k++) begin
      if (sel < 0 && f[(m_rr + k) % NC]) sel = (m_rr + k) % NC;
    end
    disp = rv && !fl && q.size() != 0 && sel >= 0;
    pu   = v && q.size() < DEPTH && !fl;
    if (disp) exp_q.push_back('{q[0], sel});
    if (!rv) begin
      q.delete();
      m_rr = 0;
      m_issued = '0;
      m_stall = '0;
    end else begin
      if (!fl && q.size() != 0 && f == '0) m_stall++;
      if (fl) begin
        q.delete();
      end else begin
        if (disp) begin
          q.delete(0);
          m_rr = (sel + 1) % NC;
          m_issued++;
        end
        if (pu) q.push_back(d);
      end
    end
  endtask

  function automatic logic [W-1:0] next_inst();
    logic [W-1:0] r;
    r   = W'($urandom) & W'(32'h0000_FFFF);
    seq = seq + 1;
    return W'(seq << 16) | r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("issue_valid", 64'(issue_valid), 64'(NC'(1) << e.coll));
      check("issue_inst", 64'(issue_inst), 64'(e.inst));
    end else if (issue_valid != '0) begin
      check("spurious_issue", 64'(issue_valid), 64'd0);
    end
  end

  initial begin
    // Reset held two cycles, then idle.
    repeat (2) cycle(1'b0, 1'b0, '0, '0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, '0, '0, 1'b0);

    // Fill with no free collector, one refused push while full, then drain on units 0/1.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, W'(32'hA0 + i), 4'b0000, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, '0, 4'b0011, 1'b0);
    cycle(1'b1, 1'b0, '0, 4'b0000, 1'b0);

    // Round robin with skip: rr_ptr sits at 2 after the drain above.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, W'(32'hB0 + i), 4'b0000, 1'b0);
    cycle(1'b1, 1'b0, '0, 4'b1001, 1'b0);
    cycle(1'b1, 1'b0, '0, 4'b1111, 1'b0);
    cycle(1'b1, 1'b0, '0, 4'b1111, 1'b0);

    // Full with simultaneous dispatch: push refused, slot returns next cycle.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, W'(32'hC0 + i), 4'b0000, 1'b0);
    cycle(1'b1, 1'b1, W'(32'hCF), 4'b0100, 1'b0);
    cycle(1'b1, 1'b0, '0, 4'b0000, 1'b0);

    // Flush beats push and dispatch with three entries buffered.
    cycle(1'b1, 1'b1, W'(32'hDD), 4'b1111, 1'b1);
    repeat (2) cycle(1'b1, 1'b0, '0, 4'b1111, 1'b0);

    // Stall and issue counting, then a flush that must leave the counters alone.
    repeat (3) cycle(1'b1, 1'b1, W'(32'hE0), 4'b0000, 1'b0);
    repeat (5) cycle(1'b1, 1'b0, '0, 4'b0000, 1'b0);
    repeat (2) cycle(1'b1, 1'b0, '0, 4'b0010, 1'b0);
    cycle(1'b1, 1'b0, '0, 4'b0000, 1'b1);
    repeat (2) cycle(1'b1, 1'b0, '0, 4'b0000, 1'b0);

    // Randomized traffic with occasional flush and mid-run reset.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(99) != 0), ($urandom_range(9) < 7), next_inst(),
            NC'($urandom_range((1 << NC) - 1)) & ((i % 64 < 16) ? 4'b0000 : 4'b1111),
            ($urandom_range(39) == 0));
    end

    repeat (DEPTH + 2) cycle(1'b1, 1'b0, '0, 4'b1111, 1'b0);
    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gelato_warpskd_collector_buf.md
Name: gelato_warpskd_collector_buf

Overview:
- Parametrised successor to the single-slot warp-scheduler-to-operand-collector link.
- Buffers issued instructions in a DEPTH-entry FIFO using a valid/ready handshake on the scheduler side.
- Dispatches at most one instruction per cycle to one of NUM_COLLECTORS operand-collector units, chosen round-robin among the units that report free.
- Sits between the warp scheduler and the collector array. Supports a flush for branch/exception redirect.

Parameters:
- INST_WIDTH, 64: bit width of one packed instruction (inst_t).
- DEPTH, 4: FIFO entries. Power of two, >= 2.
- NUM_COLLECTORS, 2: operand-collector units. Must be >= 1.
- CNT_W, 32: width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  discard all buffered entries.
- in_valid  in  1  scheduler presents an instruction.
- in_inst  in  INST_WIDTH  instruction payload.
- in_ready  out  1  buffer can accept. Registered, equals !full.
- coll_free  in  NUM_COLLECTORS  per-unit idle indication.
- issue_valid  out  NUM_COLLECTORS  one-hot dispatch strobe.
- issue_inst  out  INST_WIDTH  head instruction, broadcast to all units.
- count  out  $clog2(DEPTH)+1  current occupancy.
- stat_issued  out  CNT_W  instructions dispatched (feature only).
- stat_stall  out  CNT_W  cycles non-empty with no free unit (feature only).

Behaviour:
- Clock and reset
  - Single clock domain. All state updates on the rising edge of clk.
  - Reset is synchronous and active-low: when rst_n=0 at an edge, head=tail=0, count=0, rr_ptr=0, and stat counters are cleared.
  - Outputs after reset: in_ready=1, issue_valid=0, issue_inst=0 (storage is not cleared; issue_inst is masked to 0 while empty), count=0.
  - Reset asserted mid-operation drops all entries with no dispatch in that cycle.
- Push
  - push = in_valid & in_ready & !flush. Writes mem[tail], tail++ modulo DEPTH.
  - in_ready is a function of registered count only. No combinational path from any input.
  - When full, in_ready=0 even if a dispatch occurs the same cycle; the slot reappears next cycle.
- Dispatch
  - Possible when count!=0 and |coll_free.
  - Select the first i with coll_free[i]=1, searching from rr_ptr upward with wrap-around.
  - issue_valid = onehot(i), issue_inst = mem[head]. Combinational from coll_free and registered state.
  - Transfer completes in the same cycle; there is no separate ready from the collectors.
  - On dispatch: head++ modulo DEPTH, rr_ptr <= (i+1) mod NUM_COLLECTORS.
  - With no dispatch, rr_ptr holds.
- Latency and occupancy
  - Latency: an instruction pushed at edge N is dispatchable in cycle N+1 at the earliest. There is no bypass.
  - Simultaneous push and dispatch leaves count unchanged.
  - count saturates at neither end: push is impossible when full and dispatch is impossible when empty.
- Flush
  - Dominates push and dispatch.
  - In the flush cycle issue_valid is forced to 0.
  - At the next edge head=tail=0 and count=0. rr_ptr holds.
- Pointers and gating
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - count is kept as a separate register.
  - NUM_COLLECTORS=1 degenerates to issue_valid = (count!=0) & coll_free[0], with rr_ptr fixed at 0.

Optional Feature:
- Macro GELATO_WARPSKD_COLLECTOR_BUF_STATS_EN.
- When defined:
  - stat_issued increments by 1 on each dispatch.
  - stat_stall increments on each cycle with count!=0, coll_free==0 and !flush.
  - Both counters wrap at 2^CNT_W and clear on reset only (not on flush).
- When undefined:
  - Both ports still exist and are tied to 0.
  - No counter flops are generated.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, then release -> in_ready=1, count=0, issue_valid=0 for all cycles with no input.
- Fill and drain (DEPTH=4): push A,B,C,D with coll_free=0 -> count=4 and in_ready=0. Then coll_free=2'b11 -> issue order A,B,C,D on collectors 0,1,0,1, one per cycle, and count ends at 0.
- Round-robin with skip (NUM_COLLECTORS=4): rr_ptr=2 and coll_free=4'b1001 -> issue_valid=4'b1000 and rr_ptr becomes 0. The next dispatch with coll_free=4'b1111 -> issue_valid=4'b0001.
- Full with simultaneous dispatch: count=4, in_valid=1, one unit free -> dispatch occurs, push is refused (in_ready=0), count=3. The following cycle in_ready=1.
- Flush priority: count=3, flush=1 together with in_valid=1 and coll_free=all ones -> issue_valid=0 that cycle, count=0 and in_ready=1 the next cycle, and the pushed instruction is never issued.
- Stats (macro defined): 5 cycles with count!=0 and coll_free=0, then 3 dispatches -> stat_stall=5 and stat_issued=3. A flush leaves both unchanged. With the macro undefined, both read 0.
